mul_pipe: RTL and testbench

//  Parametrised, pipelined integer multiplier for the EXEC stage; successor of the single-stage M1 unit.

---
 rtl/mul_pipe_pkg.sv | 37 +++
 rtl/mul_pipe_if.sv | 41 ++++
 rtl/mul_pipe_reg.sv | 54 +++++
 rtl/mul_pipe.sv | 177 +++++++++++++++++
 tb/tb_mul_pipe.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mul_pipe_pkg
//   Shared definitions for the pipelined EXEC-stage multiplier:
//   - R-type opcode and the four multiply function codes
//   - 2-bit multiply mode encoding
//   - decode result struct and small mode-property helpers
// -----------------------------------------------------------------------------
package mul_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_MUL   = 6'h18;
    localparam logic [5:0] FN_MULU  = 6'h19;
    localparam logic [5:0] FN_MULH  = 6'h1C;
    localparam logic [5:0] FN_MULHU = 6'h1D;

    typedef enum logic [1:0] {
        MUL_MODE_MUL   = 2'd0,  // signed,   low half
        MUL_MODE_MULU  = 2'd1,  // unsigned, low half
        MUL_MODE_MULH  = 2'd2,  // signed,   high half
        MUL_MODE_MULHU = 2'd3   // unsigned, high half
    } mul_mode_e;

    typedef struct packed {
        logic      ok;
        mul_mode_e mode;
    } mul_dec_t;

    function automatic logic mode_is_signed(input mul_mode_e m);
        return (m == MUL_MODE_MUL) || (m == MUL_MODE_MULH);
    endfunction

    function automatic logic mode_is_high(input mul_mode_e m);
        return (m == MUL_MODE_MULH) || (m == MUL_MODE_MULHU);
    endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// -----------------------------------------------------------------------------
// mul_pipe_if
//   Issue/retire bundle between the EXEC stage / hazard unit and mul_pipe.
//   master : issuing side (drives op, operands, stall, flush)
//   slave  : the multiplier (drives result, flags, destination, busy)
//   Inputs : valid_in, stall, flush, regwrite_in, wreg_in, opcode,
//            funct_code, src1, src2
//   Outputs: valid_out, regwrite_out, dst_reg, result, zero, overflow, busy
// -----------------------------------------------------------------------------
interface mul_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              valid_in;
    logic              stall;
    logic              flush;
    logic              regwrite_in;
    logic [ADDR_W-1:0] wreg_in;
    logic [5:0]        opcode;
    logic [5:0]        funct_code;
    logic [WIDTH-1:0]  src1;
    logic [WIDTH-1:0]  src2;

    logic              valid_out;
    logic              regwrite_out;
    logic [ADDR_W-1:0] dst_reg;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic              overflow;
    logic              busy;

    modport master (
        output valid_in, stall, flush, regwrite_in, wreg_in, opcode, funct_code, src1, src2,
        input  valid_out, regwrite_out, dst_reg, result, zero, overflow, busy
    );

    modport slave (
        input  valid_in, stall, flush, regwrite_in, wreg_in, opcode, funct_code, src1, src2,
        output valid_out, regwrite_out, dst_reg, result, zero, overflow, busy
    );
endinterface

// File: rtl/mul_pipe_reg.sv
// -----------------------------------------------------------------------------
// mul_pipe_reg
//   One pipeline stage: a valid bit plus a W-bit payload.
//   clk, rst  : clock, asynchronous active-high reset (clears valid and payload)
//   en_i      : advance enable (low = hold everything)
//   clr_i     : kill the stage valid; takes priority over en_i
//   vld_i     : incoming valid
//   data_i    : incoming payload
//   vld_o     : stage valid
//   data_o    : stage payload
//   The payload only loads with a valid op, so an empty stage keeps the last
//   real payload, which keeps don't-care outputs deterministic.
// -----------------------------------------------------------------------------
module mul_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (en_i) begin
            vld_d = vld_i;
            if (vld_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
endmodule

// File: rtl/mul_pipe.sv
// -----------------------------------------------------------------------------
// mul_pipe
//   Pipelined WIDTH x WIDTH integer multiplier (MUL/MULU/MULH/MULHU).
//   An op accepted at clock edge N is presented on the outputs after edge
//   N+STAGES-1. Throughput one op per cycle.
//   Parameters: WIDTH (even), ADDR_W, STAGES (2..8).
//   Ports:
//     clk    : clock, rising edge
//     reset  : asynchronous active-high reset, drops every in-flight op
//     mp     : mul_pipe_if.slave bundle (op in, stall/flush, result out)
//   Stage map:
//     S1 : decode, extend operands, two registered partial products
//     S2 : registered full product; result select and flags are
//          combinational on this register
//     S3..STAGES : delay registers for the selected result and flags
// -----------------------------------------------------------------------------
module mul_pipe
    import mul_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int STAGES = 3
) (
    input  logic        clk,
    input  logic        reset,
    mul_pipe_if.slave   mp
);
    localparam int H    = WIDTH / 2;
    localparam int PW   = WIDTH + H + 2;       // (WIDTH+1) x (H+1) signed product
    localparam int SW   = 2 * WIDTH + 2;       // sum width before truncation
    localparam int S1_W = 3 + ADDR_W + 2 * PW; // mode, rw, wreg, p_hi, p_lo
    localparam int S2_W = 4 + ADDR_W + 2 * WIDTH; // loaded, mode, rw, wreg, prod
    localparam int D_W  = 3 + ADDR_W + WIDTH;  // rw, wreg, result, zero, ovf

    function automatic mul_dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        mul_dec_t d;
        d.ok   = 1'b0;
        d.mode = MUL_MODE_MUL;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_MUL:   begin d.ok = 1'b1; d.mode = MUL_MODE_MUL;   end
                FN_MULU:  begin d.ok = 1'b1; d.mode = MUL_MODE_MULU;  end
                FN_MULH:  begin d.ok = 1'b1; d.mode = MUL_MODE_MULH;  end
                FN_MULHU: begin d.ok = 1'b1; d.mode = MUL_MODE_MULHU; end
                default:  ;
            endcase
        end
        return d;
    endfunction

    logic en, clr;
    assign en  = ~mp.stall;
    assign clr = mp.flush;

    // ---- S1: decode, operand extension, partial products ----
    mul_dec_t              dec;
    logic                  sgn;
    logic signed [PW-1:0]  a_w, blo_w, bhi_w;
    logic signed [PW-1:0]  p_lo_s1, p_hi_s1;

    assign dec = decode(mp.opcode, mp.funct_code);
    assign sgn = mode_is_signed(dec.mode);

    // Operands widened straight to PW: same value as the WIDTH+1 extension.
    // The low half of b is always unsigned; only the upper half carries sign.
    assign a_w   = {{(PW-WIDTH){sgn & mp.src1[WIDTH-1]}}, mp.src1};
    assign blo_w = {{(PW-H){1'b0}}, mp.src2[H-1:0]};
    assign bhi_w = {{(PW-H){sgn & mp.src2[WIDTH-1]}}, mp.src2[WIDTH-1:H]};

    assign p_lo_s1 = a_w * blo_w;
    assign p_hi_s1 = a_w * bhi_w;

    logic             vld_p1;
    logic [S1_W-1:0]  s1_q;

    mul_pipe_reg #(.W(S1_W)) u_s1 (
        .clk    (clk),
        .rst    (reset),
        .en_i   (en),
        .clr_i  (clr),
        .vld_i  (mp.valid_in & dec.ok),
        .data_i ({dec.mode, mp.regwrite_in, mp.wreg_in, p_hi_s1, p_lo_s1}),
        .vld_o  (vld_p1),
        .data_o (s1_q)
    );

    // ---- S2: recombine partial products into the full product ----
    mul_mode_e             mode_p1;
    logic                  rw_p1;
    logic [ADDR_W-1:0]     wreg_p1;
    logic signed [PW-1:0]  p_lo_p1, p_hi_p1;
    logic signed [SW-1:0]  sum_s2;
    logic [2*WIDTH-1:0]    prod_s2;

    assign mode_p1 = mul_mode_e'(s1_q[S1_W-1 -: 2]);
    assign rw_p1   = s1_q[S1_W-3];
    assign wreg_p1 = s1_q[2*PW +: ADDR_W];
    assign p_hi_p1 = s1_q[PW +: PW];
    assign p_lo_p1 = s1_q[0 +: PW];

    assign sum_s2  = {{(SW-PW){p_lo_p1[PW-1]}}, p_lo_p1}
                   + ({{(SW-PW){p_hi_p1[PW-1]}}, p_hi_p1} <<< H);
    assign prod_s2 = sum_s2[2*WIDTH-1:0];

    logic             vld_p2;
    logic [S2_W-1:0]  s2_q;

    // The leading 1 marks that S2 has held a real product since reset, so
    // the zero flag reads 0 out of reset instead of flagging the cleared product.
    mul_pipe_reg #(.W(S2_W)) u_s2 (
        .clk    (clk),
        .rst    (reset),
        .en_i   (en),
        .clr_i  (clr),
        .vld_i  (vld_p1),
        .data_i ({1'b1, mode_p1, rw_p1, wreg_p1, prod_s2}),
        .vld_o  (vld_p2),
        .data_o (s2_q)
    );

    // ---- S2 output side: half select and flags ----
    logic               ld_p2;
    mul_mode_e          mode_p2;
    logic               rw_p2;
    logic [ADDR_W-1:0]  wreg_p2;
    logic [2*WIDTH-1:0] prod_p2;
    logic [WIDTH-1:0]   hi_p2, lo_p2, res_sel;
    logic               zero_sel, ovf_sel;

    assign ld_p2   = s2_q[S2_W-1];
    assign mode_p2 = mul_mode_e'(s2_q[S2_W-2 -: 2]);
    assign rw_p2   = s2_q[2*WIDTH+ADDR_W];
    assign wreg_p2 = s2_q[2*WIDTH +: ADDR_W];
    assign prod_p2 = s2_q[0 +: 2*WIDTH];
    assign hi_p2   = prod_p2[2*WIDTH-1:WIDTH];
    assign lo_p2   = prod_p2[WIDTH-1:0];

    assign res_sel  = mode_is_high(mode_p2) ? hi_p2 : lo_p2;
    assign zero_sel = ld_p2 & (res_sel == '0);

    always_comb begin
        ovf_sel = 1'b0;
        case (mode_p2)
            MUL_MODE_MUL:  ovf_sel = (hi_p2 != {WIDTH{lo_p2[WIDTH-1]}});
            MUL_MODE_MULU: ovf_sel = (hi_p2 != '0);
            default:       ovf_sel = 1'b0;
        endcase
    end

    // ---- S3..STAGES: delay registers ----
    logic [STAGES:2]            dly_vld;
    logic [STAGES:2][D_W-1:0]   dly_data;

    assign dly_vld[2]  = vld_p2;
    assign dly_data[2] = {rw_p2, wreg_p2, res_sel, zero_sel, ovf_sel};

    for (genvar k = 3; k <= STAGES; k++) begin : g_dly
        mul_pipe_reg #(.W(D_W)) u_dly (
            .clk    (clk),
            .rst    (reset),
            .en_i   (en),
            .clr_i  (clr),
            .vld_i  (dly_vld[k-1]),
            .data_i (dly_data[k-1]),
            .vld_o  (dly_vld[k]),
            .data_o (dly_data[k])
        );
    end

    // ---- Outputs ----
    logic rw_out;

    assign {rw_out, mp.dst_reg, mp.result, mp.zero, mp.overflow} = dly_data[STAGES];
    assign mp.valid_out    = dly_vld[STAGES];
    assign mp.regwrite_out = rw_out & dly_vld[STAGES];
    assign mp.busy         = |{dly_vld, vld_p1};
endmodule

// File: tb/tb_mul_pipe.sv
module tb_mul_pipe;
    import mul_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mul_pipe_if #(.WIDTH(32), .ADDR_W(5)) if2 ();
    mul_pipe_if #(.WIDTH(32), .ADDR_W(5)) if3 ();
    mul_pipe_if #(.WIDTH(32), .ADDR_W(5)) if5 ();

    mul_pipe #(.WIDTH(32), .ADDR_W(5), .STAGES(2)) dut2 (.clk(clk), .reset(reset), .mp(if2));
    mul_pipe #(.WIDTH(32), .ADDR_W(5), .STAGES(3)) dut3 (.clk(clk), .reset(reset), .mp(if3));
    mul_pipe #(.WIDTH(32), .ADDR_W(5), .STAGES(5)) dut5 (.clk(clk), .reset(reset), .mp(if5));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic rw, input logic [4:0] wr);
        if2.valid_in = v; if2.opcode = op; if2.funct_code = fn; if2.src1 = a; if2.src2 = b;
        if2.regwrite_in = rw; if2.wreg_in = wr;
        if3.valid_in = v; if3.opcode = op; if3.funct_code = fn; if3.src1 = a; if3.src2 = b;
        if3.regwrite_in = rw; if3.wreg_in = wr;
        if5.valid_in = v; if5.opcode = op; if5.funct_code = fn; if5.src1 = a; if5.src2 = b;
        if5.regwrite_in = rw; if5.wreg_in = wr;
    endtask

    task automatic ctl(input logic st, input logic fl);
        if2.stall = st; if2.flush = fl;
        if3.stall = st; if3.flush = fl;
        if5.stall = st; if5.flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, OP_RTYPE, FN_MUL, 32'h0, 32'h0, 1'b0, 5'd0);
    endtask

    // Present one op and advance three edges: the STAGES=3 unit then shows it.
    task automatic issue_one(input logic [5:0] op, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic rw, input logic [4:0] wr);
        drive(1'b1, op, fn, a, b, rw, wr);
        tick();
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        ctl(1'b0, 1'b0);
        tick();
        tick();
        n_tests++; if (if3.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", if3.valid_out); end
        n_tests++; if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", if3.busy); end
        n_tests++; if (if3.result !== 32'h0) begin n_fail++; $display("FAIL rst_result got %h want 0", if3.result); end
        n_tests++; if (if3.zero !== 1'b0) begin n_fail++; $display("FAIL rst_zero got %b want 0", if3.zero); end
        n_tests++; if (if3.dst_reg !== 5'd0) begin n_fail++; $display("FAIL rst_dst got %h want 0", if3.dst_reg); end
        n_tests++; if (if2.zero !== 1'b0) begin n_fail++; $display("FAIL rst_zero_s2 got %b want 0", if2.zero); end
        n_tests++; if (if2.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid_s2 got %b want 0", if2.valid_out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mul_basic();
        drive(1'b1, OP_RTYPE, FN_MUL, 32'd7, 32'hFFFFFFFD, 1'b1, 5'd5);
        tick();
        idle();
        tick();
        n_tests++; if (if3.valid_out !== 1'b0) begin n_fail++; $display("FAIL mul_early_valid got %b want 0", if3.valid_out); end
        tick();
        n_tests++; if (if3.valid_out !== 1'b1) begin n_fail++; $display("FAIL mul_valid got %b want 1", if3.valid_out); end
        n_tests++; if (if3.result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffeb", if3.result); end
        n_tests++; if (if3.overflow !== 1'b0) begin n_fail++; $display("FAIL mul_ovf got %b want 0", if3.overflow); end
        n_tests++; if (if3.zero !== 1'b0) begin n_fail++; $display("FAIL mul_zero got %b want 0", if3.zero); end
        n_tests++; if (if3.dst_reg !== 5'd5) begin n_fail++; $display("FAIL mul_dst got %0d want 5", if3.dst_reg); end
        n_tests++; if (if3.regwrite_out !== 1'b1) begin n_fail++; $display("FAIL mul_rw got %b want 1", if3.regwrite_out); end
        tick();
        n_tests++; if (if3.valid_out !== 1'b0) begin n_fail++; $display("FAIL mul_one_cycle got %b want 0", if3.valid_out); end
    endtask

    task automatic test_flags();
        issue_one(OP_RTYPE, FN_MUL, 32'h00010000, 32'h00010000, 1'b1, 5'd7);
        n_tests++; if (if3.result !== 32'h0) begin n_fail++; $display("FAIL ovf_mul_result got %h want 0", if3.result); end
        n_tests++; if (if3.zero !== 1'b1) begin n_fail++; $display("FAIL ovf_mul_zero got %b want 1", if3.zero); end
        n_tests++; if (if3.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_mul_ovf got %b want 1", if3.overflow); end
        issue_one(OP_RTYPE, FN_MULHU, 32'h00010000, 32'h00010000, 1'b1, 5'd7);
        n_tests++; if (if3.result !== 32'h1) begin n_fail++; $display("FAIL mulhu_result got %h want 1", if3.result); end
        n_tests++; if (if3.overflow !== 1'b0) begin n_fail++; $display("FAIL mulhu_ovf got %b want 0", if3.overflow); end
        n_tests++; if (if3.zero !== 1'b0) begin n_fail++; $display("FAIL mulhu_zero got %b want 0", if3.zero); end
        // Non-multiply ops become bubbles
        issue_one(6'h23, FN_MUL, 32'd3, 32'd3, 1'b1, 5'd7);
        n_tests++; if (if3.valid_out !== 1'b0) begin n_fail++; $display("FAIL bubble_opcode got %b want 0", if3.valid_out); end
        issue_one(OP_RTYPE, 6'h20, 32'd3, 32'd3, 1'b1, 5'd7);
        n_tests++; if (if3.valid_out !== 1'b0) begin n_fail++; $display("FAIL bubble_funct got %b want 0", if3.valid_out); end
    endtask

    task automatic test_high();
        issue_one(OP_RTYPE, FN_MULH, 32'h80000000, 32'h80000000, 1'b1, 5'd3);
        n_tests++; if (if3.result !== 32'h40000000) begin n_fail++; $display("FAIL mulh_min got %h want 40000000", if3.result); end
        n_tests++; if (if3.overflow !== 1'b0) begin n_fail++; $display("FAIL mulh_ovf got %b want 0", if3.overflow); end
        issue_one(OP_RTYPE, FN_MULU, 32'hFFFFFFFF, 32'd2, 1'b1, 5'd3);
        n_tests++; if (if3.result !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulu_result got %h want fffffffe", if3.result); end
        n_tests++; if (if3.overflow !== 1'b1) begin n_fail++; $display("FAIL mulu_ovf got %b want 1", if3.overflow); end
        issue_one(OP_RTYPE, FN_MUL, 32'hFFFFFFFF, 32'd2, 1'b1, 5'd3);
        n_tests++; if (if3.result !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mul_neg_result got %h want fffffffe", if3.result); end
        n_tests++; if (if3.overflow !== 1'b0) begin n_fail++; $display("FAIL mul_neg_ovf got %b want 0", if3.overflow); end
        issue_one(OP_RTYPE, FN_MULH, 32'hFFFFFFFF, 32'd2, 1'b1, 5'd3);
        n_tests++; if (if3.result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulh_neg got %h want ffffffff", if3.result); end
        issue_one(OP_RTYPE, FN_MULHU, 32'hFFFFFFFF, 32'd2, 1'b1, 5'd3);
        n_tests++; if (if3.result !== 32'h1) begin n_fail++; $display("FAIL mulhu_big got %h want 1", if3.result); end
    endtask

    task automatic test_back_to_back();
        logic        exp_v [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_r [9] = '{32'd0, 32'd0, 32'd6, 32'd6, 32'd6, 32'd20, 32'd42, 32'd72, 32'd0};
        logic [4:0]  exp_d [9] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd0};
        for (int e = 0; e < 9; e++) begin
            ctl(1'b0, 1'b0);
            case (e)
                0: drive(1'b1, OP_RTYPE, FN_MULU, 32'd2, 32'd3, 1'b1, 5'd1);
                1: drive(1'b1, OP_RTYPE, FN_MULU, 32'd4, 32'd5, 1'b1, 5'd2);
                2: drive(1'b1, OP_RTYPE, FN_MULU, 32'd6, 32'd7, 1'b1, 5'd3);
                3, 4: begin
                    ctl(1'b1, 1'b0);
                    drive(1'b1, OP_RTYPE, FN_MULU, 32'd8, 32'd9, 1'b1, 5'd4);
                end
                5: drive(1'b1, OP_RTYPE, FN_MULU, 32'd8, 32'd9, 1'b1, 5'd4);
                default: idle();
            endcase
            tick();
            n_tests++;
            if (if3.valid_out !== exp_v[e]) begin
                n_fail++; $display("FAIL b2b_valid[%0d] got %b want %b", e, if3.valid_out, exp_v[e]);
            end
            if (exp_v[e]) begin
                n_tests++;
                if (if3.result !== exp_r[e] || if3.dst_reg !== exp_d[e]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d] got %0d/r%0d want %0d/r%0d", e, if3.result, if3.dst_reg, exp_r[e], exp_d[e]);
                end
            end
            if (e == 3 || e == 4) begin
                n_tests++; if (if3.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d] got %b want 1", e, if3.busy); end
            end
        end
        ctl(1'b0, 1'b0);
    endtask

    task automatic test_flush();
        drive(1'b1, OP_RTYPE, FN_MUL, 32'd3, 32'd3, 1'b1, 5'd8);
        tick();
        drive(1'b1, OP_RTYPE, FN_MUL, 32'd4, 32'd4, 1'b1, 5'd9);
        tick();
        ctl(1'b1, 1'b1);
        drive(1'b1, OP_RTYPE, FN_MUL, 32'd6, 32'd6, 1'b1, 5'd10);
        tick();
        n_tests++; if (if3.valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", if3.valid_out); end
        n_tests++; if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", if3.busy); end
        ctl(1'b0, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (if3.valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_leak[%0d] got %b want 0", i, if3.valid_out); end
        end
        issue_one(OP_RTYPE, FN_MUL, 32'd5, 32'd5, 1'b1, 5'd11);
        n_tests++; if (if3.valid_out !== 1'b1) begin n_fail++; $display("FAIL after_flush_valid got %b want 1", if3.valid_out); end
        n_tests++; if (if3.result !== 32'd25) begin n_fail++; $display("FAIL after_flush_result got %0d want 25", if3.result); end
        n_tests++; if (if3.dst_reg !== 5'd11) begin n_fail++; $display("FAIL after_flush_dst got %0d want 11", if3.dst_reg); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_RTYPE, FN_MUL, 32'd9, 32'd9, 1'b1, 5'd12);
        tick();
        idle();
        tick();
        #3;
        reset = 1'b1;
        #1;
        n_tests++; if (if3.valid_out !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b want 0", if3.valid_out); end
        n_tests++; if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got %b want 0", if3.busy); end
        n_tests++; if (if3.result !== 32'h0) begin n_fail++; $display("FAIL async_result got %h want 0", if3.result); end
        n_tests++; if (if3.dst_reg !== 5'd0) begin n_fail++; $display("FAIL async_dst got %0d want 0", if3.dst_reg); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (if3.valid_out !== 1'b0) begin n_fail++; $display("FAIL async_leak[%0d] got %b want 0", i, if3.valid_out); end
        end
    endtask

    task automatic test_stages_sweep();
        drive(1'b1, OP_RTYPE, FN_MUL, 32'd7, 32'hFFFFFFFD, 1'b0, 5'd13);
        tick();
        drive(1'b1, OP_RTYPE, FN_MUL, 32'h00010000, 32'h00010000, 1'b1, 5'd14);
        tick();
        idle();
        n_tests++; if (if2.valid_out !== 1'b1 || if2.result !== 32'hFFFFFFEB) begin
            n_fail++; $display("FAIL s2_op1 got %b/%h want 1/ffffffeb", if2.valid_out, if2.result); end
        n_tests++; if (if2.regwrite_out !== 1'b0 || if2.dst_reg !== 5'd13) begin
            n_fail++; $display("FAIL s2_op1_rw got %b/r%0d want 0/r13", if2.regwrite_out, if2.dst_reg); end
        n_tests++; if (if5.valid_out !== 1'b0) begin n_fail++; $display("FAIL s5_early got %b want 0", if5.valid_out); end
        tick();
        n_tests++; if (if2.valid_out !== 1'b1 || if2.result !== 32'h0 || if2.zero !== 1'b1 || if2.overflow !== 1'b1) begin
            n_fail++; $display("FAIL s2_op2 got %b/%h/z%b/o%b want 1/0/z1/o1", if2.valid_out, if2.result, if2.zero, if2.overflow); end
        n_tests++; if (if3.valid_out !== 1'b1 || if3.regwrite_out !== 1'b0) begin
            n_fail++; $display("FAIL s3_norw got v%b/rw%b want v1/rw0", if3.valid_out, if3.regwrite_out); end
        n_tests++; if (if3.result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL s3_op1 got %h want ffffffeb", if3.result); end
        tick();
        n_tests++; if (if2.valid_out !== 1'b0) begin n_fail++; $display("FAIL s2_drain got %b want 0", if2.valid_out); end
        n_tests++; if (if3.regwrite_out !== 1'b1 || if3.dst_reg !== 5'd14) begin
            n_fail++; $display("FAIL s3_op2 got rw%b/r%0d want rw1/r14", if3.regwrite_out, if3.dst_reg); end
        n_tests++; if (if5.valid_out !== 1'b0) begin n_fail++; $display("FAIL s5_e4 got %b want 0", if5.valid_out); end
        tick();
        n_tests++; if (if5.valid_out !== 1'b1 || if5.result !== 32'hFFFFFFEB || if5.regwrite_out !== 1'b0) begin
            n_fail++; $display("FAIL s5_op1 got %b/%h/rw%b want 1/ffffffeb/rw0", if5.valid_out, if5.result, if5.regwrite_out); end
        tick();
        n_tests++; if (if5.valid_out !== 1'b1 || if5.result !== 32'h0 || if5.zero !== 1'b1 || if5.overflow !== 1'b1) begin
            n_fail++; $display("FAIL s5_op2 got %b/%h/z%b/o%b want 1/0/z1/o1", if5.valid_out, if5.result, if5.zero, if5.overflow); end
        n_tests++; if (if5.regwrite_out !== 1'b1 || if5.dst_reg !== 5'd14) begin
            n_fail++; $display("FAIL s5_op2_rw got rw%b/r%0d want rw1/r14", if5.regwrite_out, if5.dst_reg); end
        tick();
        n_tests++; if (if5.valid_out !== 1'b0) begin n_fail++; $display("FAIL s5_drain got %b want 0", if5.valid_out); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_flags();
        test_high();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_stages_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
